// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: captures decoded fields, selects and forwards ALU operands,
// and presents them through a registered valid/ready handshake backed by a skid entry.
package alu_operand_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;
endpackage

module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  alu_op_e            in_alu_op,
    input  logic [RADDR_W-1:0] in_rs1_addr,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [RADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_a_sel,
    input  logic               in_b_sel,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic               in_rd_we,
    input  logic               fwd_mem_we,
    input  logic [RADDR_W-1:0] fwd_mem_rd,
    input  logic [XLEN-1:0]    fwd_mem_data,
    input  logic               fwd_wb_we,
    input  logic [RADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]    fwd_wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    data_a,
    output logic [XLEN-1:0]    data_b,
    output alu_op_e            alu_op,
    output logic [RADDR_W-1:0] out_rd_addr,
    output logic               out_rd_we
);

    typedef logic [XLEN-1:0] data_t;

    typedef struct packed {
        alu_op_e            alu_op;
        logic [RADDR_W-1:0] rs1_addr;
        logic [RADDR_W-1:0] rs2_addr;
        logic               a_sel;
        logic               b_sel;
        data_t              data_a;
        data_t              data_b;
        logic [RADDR_W-1:0] rd_addr;
        logic               rd_we;
    } entry_t;

    entry_t main_q, main_d, skid_q, skid_d, cap;
    logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic   accept, consume;

    // MEM beats WB beats the supplied base value; x0 is hard-wired to zero.
    function automatic data_t resolve(input logic [RADDR_W-1:0] addr, input data_t base);
        if (addr == '0)
            return '0;
        if (fwd_mem_we && (fwd_mem_rd == addr))
            return fwd_mem_data;
        if (fwd_wb_we && (fwd_wb_rd == addr))
            return fwd_wb_data;
        return base;
    endfunction

    // A held entry treats its own operand as the register-file value, so newer results overwrite it.
    function automatic entry_t refresh(input entry_t e);
        entry_t r;
        r = e;
        if (!e.a_sel)
            r.data_a = resolve(e.rs1_addr, e.data_a);
        if (!e.b_sel)
            r.data_b = resolve(e.rs2_addr, e.data_b);
        return r;
    endfunction

    always_comb begin
        cap          = '0;
        cap.alu_op   = in_alu_op;
        cap.rs1_addr = in_rs1_addr;
        cap.rs2_addr = in_rs2_addr;
        cap.a_sel    = in_a_sel;
        cap.b_sel    = in_b_sel;
        cap.data_a   = in_a_sel ? in_pc  : resolve(in_rs1_addr, in_rs1_data);
        cap.data_b   = in_b_sel ? in_imm : resolve(in_rs2_addr, in_rs2_data);
        cap.rd_addr  = in_rd_addr;
        cap.rd_we    = in_rd_we && (in_rd_addr != '0);
    end

    assign accept  = in_valid && in_ready;
    assign consume = main_valid_q && out_ready;

    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (main_valid_q)
            main_d = refresh(main_q);
        if (skid_valid_q)
            skid_d = refresh(skid_q);

        if (!main_valid_q || consume) begin
            if (skid_valid_q) begin
                main_d       = refresh(skid_q);
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = cap;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d       = cap;
            skid_valid_d = 1'b1;
        end

        if (flush) begin
            main_d       = main_q;
            skid_d       = skid_q;
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = main_valid_q;
    assign data_a      = main_q.data_a;
    assign data_b      = main_q.data_b;
    assign alu_op      = main_q.alu_op;
    assign out_rd_addr = main_q.rd_addr;
    assign out_rd_we   = main_q.rd_we;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table through a scoreboard queue plus
// hand-written back-pressure, stall-forwarding, flush and reset sequences.
module tb_alu_operand_stage;
    import alu_operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    alu_op_e     in_alu_op, alu_op;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, fwd_mem_rd, fwd_wb_rd, out_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_pc, in_imm, fwd_mem_data, fwd_wb_data;
    logic [31:0] data_a, data_b;
    logic        in_a_sel, in_b_sel, in_rd_we, fwd_mem_we, fwd_wb_we, out_rd_we;

    alu_operand_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_rs1_addr(in_rs1_addr), .in_rs1_data(in_rs1_data),
        .in_rs2_addr(in_rs2_addr), .in_rs2_data(in_rs2_data),
        .in_pc(in_pc), .in_imm(in_imm), .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
        .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
        .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_a(data_a), .data_b(data_b), .alu_op(alu_op),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        alu_op_e     op;
        logic [4:0]  rs1;
        logic [31:0] rs1d;
        logic [4:0]  rs2;
        logic [31:0] rs2d;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        asel;
        logic        bsel;
        logic [4:0]  rd;
        logic        rdwe;
        logic        mwe;
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        wwe;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [4:0]  erd;
        logic        erdwe;
    } vec_t;

    typedef struct {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    int   items  = 0;
    vec_t tbl[10];

    function automatic vec_t base();
        vec_t v;
        v.op = ALU_ADD; v.rs1 = 5'd5; v.rs1d = 32'd7; v.rs2 = 5'd6; v.rs2d = 32'd3;
        v.pc = 32'h1000; v.imm = 32'd4; v.asel = 1'b0; v.bsel = 1'b0;
        v.rd = 5'd1; v.rdwe = 1'b1;
        v.mwe = 1'b0; v.mrd = 5'd0; v.mdata = 32'h0;
        v.wwe = 1'b0; v.wrd = 5'd0; v.wdata = 32'h0;
        v.ea = 32'd7; v.eb = 32'd3; v.erd = 5'd1; v.erdwe = 1'b1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        in_alu_op = v.op; in_rs1_addr = v.rs1; in_rs1_data = v.rs1d;
        in_rs2_addr = v.rs2; in_rs2_data = v.rs2d; in_pc = v.pc; in_imm = v.imm;
        in_a_sel = v.asel; in_b_sel = v.bsel; in_rd_addr = v.rd; in_rd_we = v.rdwe;
        fwd_mem_we = v.mwe; fwd_mem_rd = v.mrd; fwd_mem_data = v.mdata;
        fwd_wb_we = v.wwe; fwd_wb_rd = v.wrd; fwd_wb_data = v.wdata;
        in_valid = 1'b1;
    endtask

    task automatic push(input vec_t v);
        exp_t e;
        e.op = v.op; e.a = v.ea; e.b = v.eb; e.rd = v.erd; e.we = v.erdwe;
        sb.push_back(e);
    endtask

    // Holds the vector until accepted; keep=0 for entries that will be flushed.
    task automatic offer(input vec_t v, input bit keep);
        drive(v);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                if (keep)
                    push(v);
                @(posedge clk); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL offer_timeout: in_ready=0 for 50 cycles, required 1");
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++)
            @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d items outstanding, required 0", sb.size());
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data_a", data_a, 32'd0);
        chk("rst_data_b", data_b, 32'd0);
        chk("rst_alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
        chk("rst_rd_addr", {27'd0, out_rd_addr}, 32'd0);
        chk("rst_rd_we", {31'd0, out_rd_we}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: op=%0d a=0x%08h with empty scoreboard, required none",
                         alu_op, data_a);
            end else begin
                got = sb.pop_front();
                if (alu_op !== got.op || data_a !== got.a || data_b !== got.b ||
                    out_rd_addr !== got.rd || out_rd_we !== got.we) begin
                    errors++;
                    $display("FAIL item%0d: got op=%0d a=0x%08h b=0x%08h rd=%0d we=%b, required op=%0d a=0x%08h b=0x%08h rd=%0d we=%b",
                             items, alu_op, data_a, data_b, out_rd_addr, out_rd_we,
                             got.op, got.a, got.b, got.rd, got.we);
                end
                items++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v, a, b, c, x, y;

        tbl[0] = base();
        v = base(); v.op = ALU_SUB; v.rd = 5'd2; v.erd = 5'd2; tbl[1] = v;
        v = base(); v.mwe = 1'b1; v.mrd = 5'd5; v.mdata = 32'h100;
        v.wwe = 1'b1; v.wrd = 5'd5; v.wdata = 32'h200; v.ea = 32'h100; tbl[2] = v;
        v.rs1 = 5'd0; v.rs1d = 32'h1234; v.ea = 32'h0; tbl[3] = v;
        v = base(); v.rs1 = 5'd0; v.rs1d = 32'h5678; v.mwe = 1'b1; v.mrd = 5'd0;
        v.mdata = 32'h999; v.ea = 32'h0; tbl[4] = v;
        v = base(); v.asel = 1'b1; v.bsel = 1'b1; v.pc = 32'h80; v.imm = 32'hFFFF_FFFC;
        v.mwe = 1'b1; v.mrd = 5'd5; v.mdata = 32'h100; v.wwe = 1'b1; v.wrd = 5'd6;
        v.wdata = 32'h200; v.ea = 32'h80; v.eb = 32'hFFFF_FFFC; tbl[5] = v;
        v = base(); v.op = ALU_SLL; v.wwe = 1'b1; v.wrd = 5'd6; v.wdata = 32'h200;
        v.eb = 32'h200; tbl[6] = v;
        v = base(); v.mwe = 1'b0; v.mrd = 5'd5; v.mdata = 32'h100; v.wwe = 1'b1;
        v.wrd = 5'd5; v.wdata = 32'h200; v.ea = 32'h200; tbl[7] = v;
        v = base(); v.op = ALU_XOR; v.rd = 5'd0; v.rdwe = 1'b1; v.erd = 5'd0;
        v.erdwe = 1'b0; tbl[8] = v;
        v = base(); v.op = ALU_AND; v.rs1 = 5'd7; v.rs2 = 5'd7; v.mwe = 1'b1;
        v.mrd = 5'd7; v.mdata = 32'hAA; v.ea = 32'hAA; v.eb = 32'hAA; v.rd = 5'd31;
        v.erd = 5'd31; tbl[9] = v;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(base()); in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_reset_state();

        // 1-cycle latency, then empty again
        @(posedge clk); #1;
        offer(tbl[0], 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // back-to-back table vectors with out_ready held high
        for (int i = 0; i < 10; i++)
            offer(tbl[i], 1'b1);
        in_valid = 1'b0;
        drain();

        // back-pressure: two accepted, third waits until release
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = base(); a.op = ALU_SUB; a.rd = 5'd3; a.erd = 5'd3;
        b = base(); b.op = ALU_OR;  b.rd = 5'd4; b.erd = 5'd4;
        c = base(); c.op = ALU_AND; c.rd = 5'd5; c.erd = 5'd5;
        drive(a);
        @(negedge clk);
        chk("bp_ready_1", {31'd0, in_ready}, 32'd1);
        push(a);
        @(posedge clk); #1;
        drive(b);
        @(negedge clk);
        chk("bp_ready_2", {31'd0, in_ready}, 32'd1);
        push(b);
        @(posedge clk); #1;
        drive(c);
        @(negedge clk);
        chk("bp_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_head_op", {28'd0, alu_op}, {28'd0, ALU_SUB});
        @(negedge clk);
        chk("bp_ready_held", {31'd0, in_ready}, 32'd0);
        chk("bp_head_stable", {28'd0, alu_op}, {28'd0, ALU_SUB});
        @(posedge clk); #1;
        out_ready = 1'b1;
        offer(c, 1'b1);
        in_valid = 1'b0;
        drain();

        // operands stalled in main and skid pick up a later WB result
        @(posedge clk); #1;
        out_ready = 1'b0;
        x = base(); x.op = ALU_SLT; x.rs2 = 5'd9; x.rs2d = 32'h11; x.eb = 32'h55;
        x.rd = 5'd10; x.erd = 5'd10;
        y = base(); y.op = ALU_SRA; y.rs1 = 5'd9; y.rs1d = 32'h22; y.ea = 32'h55;
        y.rd = 5'd11; y.erd = 5'd11;
        offer(x, 1'b1);
        offer(y, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_b_before", data_b, 32'h11);
        @(posedge clk); #1;
        fwd_wb_we = 1'b1; fwd_wb_rd = 5'd9; fwd_wb_data = 32'h55;
        @(posedge clk); #1;
        fwd_wb_we = 1'b0; fwd_wb_data = 32'h0;
        @(negedge clk);
        chk("stall_b_after", data_b, 32'h55);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // flush with both entries full and a new input offered
        @(posedge clk); #1;
        out_ready = 1'b0;
        a = base(); a.op = ALU_SUB; a.rs1d = 32'h31; a.ea = 32'h31;
        b = base(); b.op = ALU_OR;
        c = base(); c.op = ALU_AND;
        offer(a, 1'b0);
        offer(b, 1'b0);
        drive(c);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush_data_kept", data_a, 32'h31);
        chk("flush_op_kept", {28'd0, alu_op}, {28'd0, ALU_SUB});
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("flush_dropped", {31'd0, out_valid}, 32'd0);
        end

        // reset in the same situation
        @(posedge clk); #1;
        out_ready = 1'b0;
        offer(a, 1'b0);
        offer(b, 1'b0);
        drive(c);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk_reset_state();

        @(posedge clk); #1;
        out_ready = 1'b1;
        offer(tbl[7], 1'b1);
        in_valid = 1'b0;
        drain();

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- ID/EX boundary register that feeds the ALU.
- Captures decoded instruction fields from decode and selects ALU operands: rs1 or pc for data_a, rs2 or imm for data_b.
- Resolves register hazards by forwarding from the MEM and WB stages.
- Presents registered data_a, data_b and alu_op to the ALU with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput under back-pressure.

Parameters:
- XLEN, 32, operand width; equals data_t width.
- RADDR_W, 5, register-file address width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all held entries (branch mispredict/trap)
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage can accept
- in_alu_op  in  alu_op_e  decoded ALU operation
- in_rs1_addr  in  RADDR_W  source 1 register index
- in_rs1_data  in  XLEN  register-file read, source 1
- in_rs2_addr  in  RADDR_W  source 2 register index
- in_rs2_data  in  XLEN  register-file read, source 2
- in_pc  in  XLEN  instruction PC
- in_imm  in  XLEN  sign-extended immediate
- in_a_sel  in  1  0: data_a=rs1, 1: data_a=pc
- in_b_sel  in  1  0: data_b=rs2, 1: data_b=imm
- in_rd_addr  in  RADDR_W  destination register
- in_rd_we  in  1  destination write enable
- fwd_mem_we  in  1  MEM stage will write rd
- fwd_mem_rd  in  RADDR_W  MEM stage rd
- fwd_mem_data  in  XLEN  MEM stage result
- fwd_wb_we  in  1  WB stage writes rd
- fwd_wb_rd  in  RADDR_W  WB stage rd
- fwd_wb_data  in  XLEN  WB stage result
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream (EX/MEM) accepts
- data_a  out  XLEN  ALU operand A
- data_b  out  XLEN  ALU operand B
- alu_op  out  alu_op_e  ALU operation
- out_rd_addr  out  RADDR_W  destination register
- out_rd_we  out  1  destination write enable

Behaviour:
- Clocking: clk only. Synchronous active-high rst. All outputs registered.
- Reset values: out_valid=0, data_a=0, data_b=0, alu_op=ALU_ADD, out_rd_addr=0, out_rd_we=0, internal skid_valid=0. in_ready=1 from the first cycle after reset.
- Storage: main entry (drives outputs) plus one skid entry.
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
- Transfers:
  - Accept when in_valid && in_ready.
  - Consume when out_valid && out_ready.
  - Latency: an accepted instruction appears on the outputs the next cycle if the main entry is empty or is being consumed.
  - If the main entry is held, the new instruction goes to the skid entry.
  - On consume with skid full, skid moves to main and skid_valid clears.
  - Throughput: 1 per cycle. Order is strictly preserved.
- Forwarding (per register-sourced operand, a_sel=0 / b_sel=0):
  - Priority: MEM > WB > register-file data.
  - Match requires fwd_*_we=1 and fwd_*_rd == source address != 0.
  - Source x0 always yields 0.
  - Applied at capture.
  - Re-applied every cycle to held main and skid entries, so stalled operands pick up later results. Each entry keeps rs1/rs2 addresses and sel bits for this.
  - pc/imm operands are never forwarded.
- out_rd_we is forced 0 when rd_addr=0.
- flush:
  - Clears out_valid and skid_valid on the next edge.
  - An input offered in the flush cycle is dropped.
  - in_ready=1 the cycle after flush.
  - flush wins over simultaneous accept/consume.
  - Data registers keep their values; only the valid bits are cleared.
- rst mid-operation: identical to flush, plus data outputs return to their reset values.
- Payload stability: while out_valid && !out_ready, alu_op, out_rd_* and sel-based selection stay stable. data_a/data_b may change only through forwarding updates.

Test Plan:
- Back-to-back ADD/SUB with out_ready=1, rs1=x5 (data 7), rs2=x6 (data 3) -> one result per cycle; data_a=7, data_b=3, 1-cycle latency, alu_op matches order.
- fwd_mem (rd=5, data 0x100) and fwd_wb (rd=5, data 0x200) both active, instr rs1=x5 -> data_a=0x100. Same case with rs1=x0 -> data_a=0.
- a_sel=1, b_sel=1, pc=0x80, imm=0xFFFFFFFC, fwd_mem rd matches rs1 -> data_a=0x80, data_b=0xFFFFFFFC, no forwarding applied.
- Hold out_ready=0 and offer 3 instructions -> first two accepted, in_ready=0 from the cycle after the second accept. Release out_ready -> all in order, no loss or duplication.
- Stalled entry with rs2=x9; fwd_wb rd=9, data 0x55 arrives during the stall -> data_b becomes 0x55 before consume.
- Both entries full, flush=1 with in_valid=1 -> out_valid=0 next cycle, in_ready=1, the input is dropped. Repeat with rst -> all outputs at reset values.
